detector_seq_ctrl: RTL and testbench
====================================

// Module: detector_seq_ctrl
// PURPOSE
//  Sequences the detector: power-up reset/strap sequencing, then periodic frame-trigger generation.
//  Sits between the Avalon register file (enable, strap, period, width) and the detector pins
//  dd_nrst / dd_i2cad / dd_seq_trigger. It monitors dd_vsync for frame count and, optionally, a watchdog.
// PARAMETERS
//  RST_HOLD_CYC  16'd1000  cycles dd_nrst held low with strap stable (>=1)
//  SETTLE_CYC    16'd5000  cycles after dd_nrst release before first trigger (>=1)
//  MIN_PERIOD    32'd64    lower clamp for frame_period
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   async active-low reset
//  enable          in   1   register bit; 1 = run sequence, 0 = return to IDLE
//  i2c_addr_sel    in   1   I2C address strap value
//  frame_period    in   32  trigger period in clk cycles
//  trig_width      in   8   trigger high time in clk cycles
//  dd_vsync        in   1   detector vsync, asynchronous to clk
//  dd_nrst         out  1   detector reset, active low
//  dd_i2cad        out  1   detector I2C address strap
//  dd_seq_trigger  out  1   frame trigger pulse
//  ready           out  1   1 while in RUN
//  frame_cnt       out  16  count of vsync rising edges in RUN
//  timeout_flag    out  1   sticky watchdog flag
// BEHAVIOUR
//  - Reset: state=IDLE; every output is 0, including dd_nrst (detector held in reset).
//  - dd_vsync passes a 2-flop synchronizer. A rise is detected on the 3rd flop.
//    Edge latency from the pin is 3 clk.
//  - FSM states: IDLE -> RST_HOLD -> SETTLE -> RUN. enable=0 in any state -> IDLE on the next clk.
//  - Leaving RUN: outputs are registered back to reset values, and frame_cnt is cleared.
//  - IDLE: dd_nrst=0, trigger=0. If enable=1, go to RST_HOLD next clk and latch i2c_addr_sel into dd_i2cad.
//  - RST_HOLD: dd_nrst=0 for exactly RST_HOLD_CYC clk. dd_i2cad stays latched.
//    A later i2c_addr_sel change is ignored until the next pass through IDLE.
//  - SETTLE: dd_nrst=1 for exactly SETTLE_CYC clk, then RUN.
//  - RUN: ready=1 and dd_nrst=1. A 32-bit phase counter runs 0..P-1 and wraps to 0.
//    P and W are latched whenever the phase is 0, so a mid-frame register write takes effect next frame.
//    - P = max(frame_period, MIN_PERIOD).
//    - W = trig_width==0 ? 1 : min(trig_width, P-1). There is always >=1 low cycle per frame.
//    - dd_seq_trigger = (phase < W). It is registered and high on the first RUN clk.
//  - Latency: enable rise -> first trigger high = 1 + RST_HOLD_CYC + SETTLE_CYC clk.
//  - frame_cnt increments on each synced vsync rise, in RUN only. It wraps 16'hFFFF -> 0.
//  - Async rst_n mid-operation: all state and outputs return to reset values immediately.
// CONFIGURATION
//  DETECTOR_SEQ_TIMEOUT_EN defined:
//    - A watchdog counter runs in RUN and clears on each synced vsync rise.
//    - If it reaches 2*P, timeout_flag is set. The watchdog saturates; triggers continue.
//    - timeout_flag is sticky and clears only on leaving RUN or on rst_n.
//  DETECTOR_SEQ_TIMEOUT_EN undefined:
//    - No watchdog logic. timeout_flag is tied 0.
// TESTING  (RST_HOLD_CYC=4, SETTLE_CYC=8, MIN_PERIOD=16)
//  1 Power-up: rst_n release, enable=1, i2c_addr_sel=1 at clk 0.
//    -> dd_i2cad=1 from clk 1; dd_nrst=0 for clk 1-4 and 1 from clk 5.
//    -> ready=1 and first trigger rise at clk 13.
//  2 Period/width: frame_period=100, trig_width=5.
//    -> trigger is high 5 clk, low 95 clk, rising every 100 clk.
//  3 Clamping:
//    - frame_period=10, trig_width=0 -> P=16, high 1 / low 15.
//    - frame_period=20, trig_width=200 -> high 19 / low 1.
//  4 Mid-frame change: write frame_period=50 at phase 30 of a 100-clk frame.
//    -> the current frame stays 100 clk; the next frame is 50 clk.
//  5 enable=0 during SETTLE, and separately during RUN.
//    -> next clk: dd_nrst=0, trigger=0, ready=0, frame_cnt=0.
//    -> re-enable repeats the full hold/settle sequence.
//  6 vsync: 3 pulses in RUN -> frame_cnt=3, with each increment 3 clk after the pin rise.
//    With DETECTOR_SEQ_TIMEOUT_EN and P=100, no vsync for 200 clk -> timeout_flag=1.
//    It stays set through later vsyncs and clears when enable=0.

Source files
------------

// File: rtl/detector_seq_ctrl.sv
// Detector power-up reset/strap sequencer and periodic frame-trigger generator.
// Optional watchdog on dd_vsync is enabled by defining DETECTOR_SEQ_TIMEOUT_EN.
module detector_seq_ctrl #(
  parameter logic [15:0] RST_HOLD_CYC = 16'd1000,
  parameter logic [15:0] SETTLE_CYC   = 16'd5000,
  parameter logic [31:0] MIN_PERIOD   = 32'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        i2c_addr_sel,
  input  logic [31:0] frame_period,
  input  logic [7:0]  trig_width,
  input  logic        dd_vsync,
  output logic        dd_nrst,
  output logic        dd_i2cad,
  output logic        dd_seq_trigger,
  output logic        ready,
  output logic [15:0] frame_cnt,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {StIdle, StRstHold, StSettle, StRun} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [31:0] phase_q;
  logic [31:0] period_q;
  logic [31:0] width_q;
  logic [2:0]  vs_sync_q;
  logic        vs_rise;
  logic [31:0] period_new;
  logic [31:0] width_new;
  logic [31:0] phase_inc;
  logic        phase_wrap;

  // Two synchronizer flops; the third flop only serves edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync_q <= 3'b000;
    end else begin
      vs_sync_q <= {vs_sync_q[1:0], dd_vsync};
    end
  end

  assign vs_rise = vs_sync_q[1] & ~vs_sync_q[2];

  always_comb begin
    period_new = (frame_period < MIN_PERIOD) ? MIN_PERIOD : frame_period;
    if (trig_width == 8'd0) begin
      width_new = 32'd1;
    end else if ({24'd0, trig_width} > period_new - 32'd1) begin
      width_new = period_new - 32'd1;
    end else begin
      width_new = {24'd0, trig_width};
    end
    phase_inc  = phase_q + 32'd1;
    phase_wrap = (phase_inc >= period_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 16'd0;
      phase_q        <= 32'd0;
      period_q       <= 32'd0;
      width_q        <= 32'd0;
      dd_nrst        <= 1'b0;
      dd_i2cad       <= 1'b0;
      dd_seq_trigger <= 1'b0;
      ready          <= 1'b0;
      frame_cnt      <= 16'd0;
    end else if (!enable) begin
      state_q        <= StIdle;
      cnt_q          <= 16'd0;
      phase_q        <= 32'd0;
      dd_nrst        <= 1'b0;
      dd_i2cad       <= 1'b0;
      dd_seq_trigger <= 1'b0;
      ready          <= 1'b0;
      frame_cnt      <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q  <= StRstHold;
          cnt_q    <= 16'd0;
          dd_i2cad <= i2c_addr_sel;
        end
        StRstHold: begin
          if (cnt_q == RST_HOLD_CYC - 16'd1) begin
            state_q <= StSettle;
            cnt_q   <= 16'd0;
            dd_nrst <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StSettle: begin
          if (cnt_q == SETTLE_CYC - 16'd1) begin
            state_q        <= StRun;
            cnt_q          <= 16'd0;
            ready          <= 1'b1;
            phase_q        <= 32'd0;
            period_q       <= period_new;
            width_q        <= width_new;
            dd_seq_trigger <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StRun: begin
          if (vs_rise) begin
            frame_cnt <= frame_cnt + 16'd1;
          end
          // Period and width are only resampled at phase 0 so a frame never tears.
          if (phase_wrap) begin
            phase_q        <= 32'd0;
            period_q       <= period_new;
            width_q        <= width_new;
            dd_seq_trigger <= 1'b1;
          end else begin
            phase_q        <= phase_inc;
            dd_seq_trigger <= (phase_inc < width_q);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef DETECTOR_SEQ_TIMEOUT_EN
  logic [32:0] wd_q;
  logic [32:0] wd_limit;

  assign wd_limit = {period_q, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q         <= 33'd0;
      timeout_flag <= 1'b0;
    end else if (state_q != StRun || !enable) begin
      wd_q         <= 33'd0;
      timeout_flag <= 1'b0;
    end else if (vs_rise) begin
      wd_q <= 33'd0;
    end else if (wd_q + 33'd1 >= wd_limit) begin
      wd_q         <= wd_limit;
      timeout_flag <= 1'b1;
    end else begin
      wd_q <= wd_q + 33'd1;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Directed bench for detector_seq_ctrl with small hold/settle/period parameters.
module tb_detector_seq_ctrl;

`ifdef DETECTOR_SEQ_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        i2c_addr_sel;
  logic [31:0] frame_period;
  logic [7:0]  trig_width;
  logic        dd_vsync;
  logic        dd_nrst;
  logic        dd_i2cad;
  logic        dd_seq_trigger;
  logic        ready;
  logic [15:0] frame_cnt;
  logic        timeout_flag;

  int vectors;
  int miscompares;

  detector_seq_ctrl #(
    .RST_HOLD_CYC(16'd4),
    .SETTLE_CYC  (16'd8),
    .MIN_PERIOD  (32'd16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .i2c_addr_sel  (i2c_addr_sel),
    .frame_period  (frame_period),
    .trig_width    (trig_width),
    .dd_vsync      (dd_vsync),
    .dd_nrst       (dd_nrst),
    .dd_i2cad      (dd_i2cad),
    .dd_seq_trigger(dd_seq_trigger),
    .ready         (ready),
    .frame_cnt     (frame_cnt),
    .timeout_flag  (timeout_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after the edge where the trigger rose; ends at the next rise.
  task automatic measure(output int hi, output int lo);
    hi = 0;
    lo = 0;
    while (dd_seq_trigger === 1'b1 && hi < 1000) begin
      hi++;
      step(1);
    end
    while (dd_seq_trigger === 1'b0 && lo < 1000) begin
      lo++;
      step(1);
    end
  endtask

  task automatic vsync_pulse(input logic [15:0] n);
    dd_vsync = 1'b1;
    step(2);
    check("vsync_lat2", {16'd0, frame_cnt}, {16'd0, n - 16'd1});
    step(1);
    check("vsync_lat3", {16'd0, frame_cnt}, {16'd0, n});
    step(3);
    dd_vsync = 1'b0;
    step(4);
  endtask

  initial begin
    int hi;
    int lo;
    int gap;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    i2c_addr_sel = 1'b0;
    frame_period = 32'd0;
    trig_width   = 8'd0;
    dd_vsync     = 1'b0;
    step(2);
    check("rst_nrst", {31'd0, dd_nrst}, 32'd0);
    check("rst_i2cad", {31'd0, dd_i2cad}, 32'd0);
    check("rst_trig", {31'd0, dd_seq_trigger}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_timeout", {31'd0, timeout_flag}, 32'd0);

    // Power-up: clk 0 is here.
    rst_n        = 1'b1;
    enable       = 1'b1;
    i2c_addr_sel = 1'b1;
    frame_period = 32'd100;
    trig_width   = 8'd5;
    step(1);
    check("pu_i2cad_c1", {31'd0, dd_i2cad}, 32'd1);
    check("pu_nrst_c1", {31'd0, dd_nrst}, 32'd0);
    i2c_addr_sel = 1'b0;
    step(3);
    check("pu_nrst_c4", {31'd0, dd_nrst}, 32'd0);
    check("pu_strap_held", {31'd0, dd_i2cad}, 32'd1);
    step(1);
    check("pu_nrst_c5", {31'd0, dd_nrst}, 32'd1);
    step(7);
    check("pu_ready_c12", {31'd0, ready}, 32'd0);
    check("pu_trig_c12", {31'd0, dd_seq_trigger}, 32'd0);
    step(1);
    check("pu_ready_c13", {31'd0, ready}, 32'd1);
    check("pu_trig_c13", {31'd0, dd_seq_trigger}, 32'd1);

    measure(hi, lo);
    check("p100_hi", hi, 32'd5);
    check("p100_lo", lo, 32'd95);

    // Clamp to MIN_PERIOD with zero width; current frame still 100.
    frame_period = 32'd10;
    trig_width   = 8'd0;
    measure(hi, lo);
    check("p100_keep_lo", lo, 32'd95);
    measure(hi, lo);
    check("pmin_hi", hi, 32'd1);
    check("pmin_lo", lo, 32'd15);

    frame_period = 32'd20;
    trig_width   = 8'd200;
    measure(hi, lo);
    measure(hi, lo);
    check("wclamp_hi", hi, 32'd19);
    check("wclamp_lo", lo, 32'd1);

    // Mid-frame period write.
    frame_period = 32'd100;
    trig_width   = 8'd5;
    measure(hi, lo);
    step(30);
    frame_period = 32'd50;
    gap = 0;
    while (dd_seq_trigger === 1'b0 && gap < 1000) begin
      gap++;
      step(1);
    end
    check("mid_rest", gap, 32'd70);
    measure(hi, lo);
    check("mid_next_hi", hi, 32'd5);
    check("mid_next_lo", lo, 32'd45);

    // Disable in RUN.
    enable = 1'b0;
    step(1);
    check("dis_run_nrst", {31'd0, dd_nrst}, 32'd0);
    check("dis_run_trig", {31'd0, dd_seq_trigger}, 32'd0);
    check("dis_run_ready", {31'd0, ready}, 32'd0);
    check("dis_run_fcnt", {16'd0, frame_cnt}, 32'd0);
    check("dis_run_to", {31'd0, timeout_flag}, 32'd0);

    // Re-enable with new strap: full sequence again.
    enable = 1'b1;
    step(1);
    check("re_i2cad", {31'd0, dd_i2cad}, 32'd0);
    check("re_nrst_c1", {31'd0, dd_nrst}, 32'd0);
    step(4);
    check("re_nrst_c5", {31'd0, dd_nrst}, 32'd1);
    step(7);
    check("re_ready_c12", {31'd0, ready}, 32'd0);
    step(1);
    check("re_ready_c13", {31'd0, ready}, 32'd1);

    // Disable during SETTLE.
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(6);
    check("set_nrst_c6", {31'd0, dd_nrst}, 32'd1);
    enable = 1'b0;
    step(1);
    check("dis_set_nrst", {31'd0, dd_nrst}, 32'd0);
    check("dis_set_ready", {31'd0, ready}, 32'd0);
    check("dis_set_trig", {31'd0, dd_seq_trigger}, 32'd0);

    // Watchdog and vsync counting with P=100.
    frame_period = 32'd100;
    trig_width   = 8'd5;
    enable       = 1'b1;
    step(13);
    check("wd_run", {31'd0, ready}, 32'd1);
    step(150);
    check("wd_early", {31'd0, timeout_flag}, 32'd0);
    step(100);
    check("wd_late", {31'd0, timeout_flag}, {31'd0, ToEn});
    check("vs_fcnt0", {16'd0, frame_cnt}, 32'd0);
    vsync_pulse(16'd1);
    vsync_pulse(16'd2);
    vsync_pulse(16'd3);
    check("vs_fcnt3", {16'd0, frame_cnt}, 32'd3);
    check("wd_sticky", {31'd0, timeout_flag}, {31'd0, ToEn});
    enable = 1'b0;
    step(1);
    check("wd_clear", {31'd0, timeout_flag}, 32'd0);
    check("vs_clear", {16'd0, frame_cnt}, 32'd0);

    // Async reset mid-RUN.
    enable = 1'b1;
    step(20);
    check("ar_ready_pre", {31'd0, ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_nrst", {31'd0, dd_nrst}, 32'd0);
    check("ar_ready", {31'd0, ready}, 32'd0);
    check("ar_trig", {31'd0, dd_seq_trigger}, 32'd0);
    check("ar_i2cad", {31'd0, dd_i2cad}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
